// File: rtl/mnist_pkg.sv
// Shared types for the MNIST inference pipeline: score format, class index type and argmax FSM states.
package mnist_pkg;

  localparam int FEATURE_BITS        = 16;
  localparam int NUM_CLASSES_DEFAULT = 10;

  typedef logic signed [FEATURE_BITS-1:0] feature_type;
  typedef logic [3:0]                     class_type;

  localparam feature_type FEATURE_MIN = {1'b1, {(FEATURE_BITS-1){1'b0}}};

  typedef enum logic {
    COLLECT,
    OUTPUT
  } argmax_state_e;

endpackage

// File: rtl/prediction_argmax_running_max.sv
// Running maximum over a stream of signed scores; ties keep the earlier index.
// With ARGMAX_MARGIN_EN defined it also tracks the runner-up score.
module running_max
  import mnist_pkg::*;
#(
  parameter int CLASS_BITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  first,
  input  feature_type           value,
  input  logic [CLASS_BITS-1:0] index,
`ifdef ARGMAX_MARGIN_EN
  output feature_type           second_best,
`endif
  output feature_type           best,
  output logic [CLASS_BITS-1:0] best_idx
);

  logic take_new;
  assign take_new = first || (value > best);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      best     <= '0;
      best_idx <= '0;
    end else if (load && take_new) begin
      best     <= value;
      best_idx <= first ? '0 : index;
    end
  end

`ifdef ARGMAX_MARGIN_EN
  // A tie with best lands in second_best so the margin reads zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      second_best <= '0;
    end else if (load) begin
      if (first) begin
        second_best <= FEATURE_MIN;
      end else if (value > best) begin
        second_best <= best;
      end else if ((value > second_best) || (value == best)) begin
        second_best <= value;
      end
    end
  end
`endif

endmodule

// File: rtl/prediction_argmax.sv
// Argmax over NUM_CLASSES streamed scores, with a valid/ready result handshake.
// Optional feature macro ARGMAX_MARGIN_EN adds margin_out = best - second_best.
module prediction_argmax
  import mnist_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEFAULT,
  parameter int CLASS_BITS  = $clog2(NUM_CLASSES)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  feature_type                  feature_in,
  input  logic                         feature_in_valid,
  output logic                         feature_in_ready,
  output logic [CLASS_BITS-1:0]        class_out,
  output feature_type                  class_score,
  output logic                         class_out_valid,
  input  logic                         class_out_ready,
`ifdef ARGMAX_MARGIN_EN
  output logic signed [FEATURE_BITS:0] margin_out,
`endif
  output logic [15:0]                  images_done
);

  argmax_state_e         state;
  logic [CLASS_BITS-1:0] idx;
  logic                  accept;
  logic                  last_beat;

  assign accept    = feature_in_valid && feature_in_ready;
  assign last_beat = (idx == CLASS_BITS'(NUM_CLASSES - 1));

  // Ready/valid are registered alongside the state so reset holds both low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= COLLECT;
      idx              <= '0;
      images_done      <= '0;
      feature_in_ready <= 1'b0;
      class_out_valid  <= 1'b0;
    end else begin
      unique case (state)
        COLLECT: begin
          feature_in_ready <= 1'b1;
          if (accept) begin
            if (last_beat) begin
              idx              <= '0;
              state            <= OUTPUT;
              feature_in_ready <= 1'b0;
              class_out_valid  <= 1'b1;
            end else begin
              idx <= idx + CLASS_BITS'(1);
            end
          end
        end
        OUTPUT: begin
          if (class_out_ready) begin
            state            <= COLLECT;
            class_out_valid  <= 1'b0;
            feature_in_ready <= 1'b1;
            images_done      <= images_done + 16'd1;
          end
        end
      endcase
    end
  end

`ifdef ARGMAX_MARGIN_EN
  feature_type second_best;
`endif

  running_max #(
    .CLASS_BITS (CLASS_BITS)
  ) u_running_max (
    .clock       (clock),
    .reset       (reset),
    .load        (accept),
    .first       (idx == '0),
    .value       (feature_in),
    .index       (idx),
`ifdef ARGMAX_MARGIN_EN
    .second_best (second_best),
`endif
    .best        (class_score),
    .best_idx    (class_out)
  );

`ifdef ARGMAX_MARGIN_EN
  assign margin_out = $signed({class_score[FEATURE_BITS-1], class_score})
                    - $signed({second_best[FEATURE_BITS-1], second_best});
`endif

endmodule

// File: tb/tb_prediction_argmax.sv
// Directed bench for prediction_argmax: basic, ties, back-pressure, mid-image reset, input gaps.
module tb_prediction_argmax;
  import mnist_pkg::*;

  localparam int N = 10;

  logic        clock = 1'b0;
  logic        reset;
  feature_type feature_in;
  logic        feature_in_valid;
  logic        feature_in_ready;
  logic [3:0]  class_out;
  feature_type class_score;
  logic        class_out_valid;
  logic        class_out_ready;
  logic [15:0] images_done;
`ifdef ARGMAX_MARGIN_EN
  logic signed [FEATURE_BITS:0] margin_out;
`endif

  int checks = 0;
  int passed = 0;
  int img[N];

  always #5 clock = ~clock;

  prediction_argmax #(
    .NUM_CLASSES (N)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .feature_in       (feature_in),
    .feature_in_valid (feature_in_valid),
    .feature_in_ready (feature_in_ready),
    .class_out        (class_out),
    .class_score      (class_score),
    .class_out_valid  (class_out_valid),
    .class_out_ready  (class_out_ready),
`ifdef ARGMAX_MARGIN_EN
    .margin_out       (margin_out),
`endif
    .images_done      (images_done)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_image(input int s[N], input bit gaps);
    for (int i = 0; i < N; i++) begin
      int gap;
      gap = gaps ? int'($urandom_range(3, 0)) : 0;
      if (gap > 0) begin
        feature_in_valid = 1'b0;
        repeat (gap) tick();
      end
      feature_in       = feature_type'(s[i]);
      feature_in_valid = 1'b1;
      for (int t = 0; t < 50 && !feature_in_ready; t++) tick();
      if (!feature_in_ready) check("beat_ready_timeout", 32'(feature_in_ready), 1);
      tick();
    end
    feature_in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input int cls, input int score);
    check({tag, "_valid"}, 32'(class_out_valid), 1);
    check({tag, "_class"}, 32'(class_out), cls);
    check({tag, "_score"}, 32'(class_score), score);
  endtask

  task automatic handshake();
    class_out_ready = 1'b1;
    tick();
    class_out_ready = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    feature_in       = '0;
    feature_in_valid = 1'b0;
    class_out_ready  = 1'b0;
    tick();
    tick();
    check("rst_ready", 32'(feature_in_ready), 0);
    check("rst_valid", 32'(class_out_valid), 0);
    check("rst_class", 32'(class_out), 0);
    check("rst_score", 32'(class_score), 0);
    check("rst_done", 32'(images_done), 0);
    reset = 1'b0;
    tick();
    check("ready_after_rst", 32'(feature_in_ready), 1);

    // Basic: max 9 at index 3, result valid one cycle after the final beat.
    img = '{0, 5, 3, 9, 2, 1, 0, 0, 0, 0};
    send_image(img, 1'b0);
    check_result("basic", 3, 9);
    check("basic_ready_low", 32'(feature_in_ready), 0);
    check("basic_done_pre", 32'(images_done), 0);
    handshake();
    check("basic_done", 32'(images_done), 1);
    check("basic_valid_drop", 32'(class_out_valid), 0);
    check("basic_ready_back", 32'(feature_in_ready), 1);

    // All scores equal and negative: lowest index wins.
    img = '{-7, -7, -7, -7, -7, -7, -7, -7, -7, -7};
    send_image(img, 1'b0);
    check_result("tie", 0, -7);
`ifdef ARGMAX_MARGIN_EN
    check("tie_margin", 32'(margin_out), 0);
`endif
    handshake();
    check("tie_done", 32'(images_done), 2);

    // Back-pressure: a pending beat must not be taken while the result waits.
    img = '{2, 4, -1, 8, 8, 3, 0, 0, 0, 0};
    send_image(img, 1'b0);
    feature_in       = feature_type'(100);
    feature_in_valid = 1'b1;
    repeat (20) begin
      tick();
      check("bp_ready", 32'(feature_in_ready), 0);
      check_result("bp", 3, 8);
    end
    handshake();
    feature_in_valid = 1'b0;
    check("bp_done", 32'(images_done), 3);
    img = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    send_image(img, 1'b0);
    check_result("bp_next", 9, 10);
    handshake();
    check("bp_next_done", 32'(images_done), 4);

    // Reset during a partial image discards it.
    feature_in       = feature_type'(50);
    feature_in_valid = 1'b1;
    repeat (4) tick();
    feature_in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_ready", 32'(feature_in_ready), 0);
    check("midrst_done", 32'(images_done), 0);
    tick();
    reset = 1'b0;
    tick();
    img = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    send_image(img, 1'b0);
    check_result("midrst", 9, 10);
    handshake();
    check("midrst_img_done", 32'(images_done), 1);

    // Random valid gaps across three images.
    img = '{-3, -9, 12, -20, 0, 12, 5, 7, 11, -1};
    send_image(img, 1'b1);
    check_result("gap_a", 2, 12);
    handshake();
    img = '{-100, -200, -50, -60, -50, -300, -51, -52, -49, -1000};
    send_image(img, 1'b1);
    check_result("gap_b", 8, -49);
    handshake();
    img = '{32767, -32768, 0, 32767, 0, 0, 0, 0, 0, 0};
    send_image(img, 1'b1);
    check_result("gap_c", 0, 32767);
    handshake();
    check("gap_done", 32'(images_done), 4);

`ifdef ARGMAX_MARGIN_EN
    img = '{100, -50, 80, 0, 0, 0, 0, 0, 0, 0};
    send_image(img, 1'b0);
    check_result("margin", 0, 100);
    check("margin_value", 32'(margin_out), 20);
    handshake();
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
